// File: rtl/arch_defs_pkg.sv
// ============================================================================
// Module      : arch_defs_pkg
// Description : Architecture-wide constants shared by the datapath and I/O.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arch_defs_pkg;
  localparam int DATA_WIDTH       = 8;
  localparam int OUT_NUM_CHANNELS = 4;
  localparam int OUT_FIFO_DEPTH   = 4;

  // A single-channel bank still needs a one-bit index field in each entry.
  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Generic single-clock FIFO, registered output, no fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/out_port_bank.sv
// ============================================================================
// Module      : out_port_bank
// Description : Buffered multi-channel OUT port with per-channel display latches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_port_bank #(
  parameter int  DATA_WIDTH   = arch_defs_pkg::DATA_WIDTH,
  parameter int  NUM_CHANNELS = arch_defs_pkg::OUT_NUM_CHANNELS,
  parameter int  DEPTH        = arch_defs_pkg::OUT_FIFO_DEPTH,
  localparam int CH_W         = arch_defs_pkg::chan_idx_w(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               out_load,
  input  logic [CH_W-1:0]                    out_chan,
  input  logic [DATA_WIDTH-1:0]              bus_data,
  output logic                               out_full,
  output logic                               ovf,
  input  logic                               clr_ovf,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [CH_W-1:0]                    m_chan,
  output logic [DATA_WIDTH-1:0]              m_data,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] chan_val,
  output logic [$clog2(DEPTH):0]             level
);

  logic                               fifo_empty;
  logic                               pop;
  logic [CH_W+DATA_WIDTH-1:0]         head;
  logic                               ovf_q, ovf_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] chan_val_q, chan_val_d;

  sync_fifo #(
    .WIDTH (CH_W + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (out_load),
    .pop   (pop),
    .wdata ({out_chan, bus_data}),
    .rdata (head),
    .full  (out_full),
    .empty (fifo_empty),
    .count (level)
  );

  assign m_valid          = !fifo_empty;
  assign pop              = m_valid && m_ready;
  assign {m_chan, m_data} = head;
  assign ovf              = ovf_q;
  assign chan_val         = chan_val_q;

  always_comb begin
    ovf_d      = ovf_q;
    chan_val_d = chan_val_q;
    // Set has priority so a drop coinciding with a clear is never lost.
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (out_load && out_full) begin
      ovf_d = 1'b1;
    end
    // Out-of-range channel tags match no slot and are silently discarded.
    if (pop) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (m_chan == CH_W'(c)) begin
          chan_val_d[c*DATA_WIDTH +: DATA_WIDTH] = m_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q      <= 1'b0;
      chan_val_q <= '0;
    end else begin
      ovf_q      <= ovf_d;
      chan_val_q <= chan_val_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_out_port_bank.sv
// ============================================================================
// Module      : tb_out_port_bank
// Description : Directed self-checking bench for out_port_bank.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_port_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_load, clr_ovf, m_ready;
  logic [1:0]  out_chan;
  logic [7:0]  bus_data;
  logic        out_full, ovf, m_valid;
  logic [1:0]  m_chan;
  logic [7:0]  m_data;
  logic [31:0] chan_val;
  logic [2:0]  level;

  logic        d3_load, d3_clr, d3_ready;
  logic [1:0]  d3_chan;
  logic [7:0]  d3_data;
  logic        d3_full, d3_ovf, d3_valid;
  logic [1:0]  d3_mchan;
  logic [7:0]  d3_mdata;
  logic [23:0] d3_chan_val;
  logic [2:0]  d3_level;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  out_port_bank dut (
    .clk(clk), .reset(reset), .out_load(out_load), .out_chan(out_chan),
    .bus_data(bus_data), .out_full(out_full), .ovf(ovf), .clr_ovf(clr_ovf),
    .m_valid(m_valid), .m_ready(m_ready), .m_chan(m_chan), .m_data(m_data),
    .chan_val(chan_val), .level(level)
  );

  out_port_bank #(.NUM_CHANNELS(3)) dut3 (
    .clk(clk), .reset(reset), .out_load(d3_load), .out_chan(d3_chan),
    .bus_data(d3_data), .out_full(d3_full), .ovf(d3_ovf), .clr_ovf(d3_clr),
    .m_valid(d3_valid), .m_ready(d3_ready), .m_chan(d3_mchan), .m_data(d3_mdata),
    .chan_val(d3_chan_val), .level(d3_level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] d);
    out_load = 1'b1; out_chan = ch; bus_data = d;
    step();
    out_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_load = 0; out_chan = 0; bus_data = 0; clr_ovf = 0; m_ready = 0;
    d3_load = 0; d3_chan = 0; d3_data = 0; d3_clr = 0; d3_ready = 0;
    repeat (3) step();
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", m_valid); end
    checks++; if (out_full !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL reset_flags full=%b ovf=%b exp=0,0", out_full, ovf); end
    checks++; if (chan_val !== 32'h0 || m_data !== 8'h0 || m_chan !== 2'd0) begin errors++; $display("FAIL reset_data chan_val=%h m_data=%h m_chan=%0d exp=0", chan_val, m_data, m_chan); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_write();
    write(2'd1, 8'h09);
    checks++; if (m_valid !== 1'b1 || m_chan !== 2'd1 || m_data !== 8'h09) begin errors++; $display("FAIL single_head valid=%b chan=%0d data=%h exp=1,1,09", m_valid, m_chan, m_data); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level got=%0d exp=1", level); end
    step();
    checks++; if (m_data !== 8'h09 || chan_val !== 32'h0) begin errors++; $display("FAIL single_hold data=%h chan_val=%h exp=09,0", m_data, chan_val); end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    checks++; if (chan_val !== 32'h0000_0900) begin errors++; $display("FAIL single_latch got=%h exp=00000900", chan_val); end
    checks++; if (level !== 3'd0 || m_valid !== 1'b0) begin errors++; $display("FAIL single_drain level=%0d valid=%b exp=0,0", level, m_valid); end
  endtask

  task automatic test_fill_overflow();
    write(2'd0, 8'h11); write(2'd1, 8'h22); write(2'd2, 8'h33); write(2'd3, 8'h44);
    checks++; if (out_full !== 1'b1 || level !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL fill full=%b level=%0d ovf=%b exp=1,4,0", out_full, level, ovf); end
    write(2'd0, 8'h55);
    checks++; if (ovf !== 1'b1 || level !== 3'd4 || m_data !== 8'h11) begin errors++; $display("FAIL overflow ovf=%b level=%0d head=%h exp=1,4,11", ovf, level, m_data); end
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%b exp=0", ovf); end
    // Push with simultaneous pop while full: push must still be rejected.
    out_load = 1'b1; out_chan = 2'd0; bus_data = 8'h66; m_ready = 1'b1;
    step();
    out_load = 1'b0;
    checks++; if (level !== 3'd3 || ovf !== 1'b1 || chan_val[7:0] !== 8'h11) begin errors++; $display("FAIL full_no_bypass level=%0d ovf=%b ch0=%h exp=3,1,11", level, ovf, chan_val[7:0]); end
    repeat (3) step();
    m_ready = 1'b0;
    checks++; if (chan_val !== 32'h4433_2211 || level !== 3'd0) begin errors++; $display("FAIL drain chan_val=%h level=%0d exp=44332211,0", chan_val, level); end
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
  endtask

  task automatic test_simultaneous();
    write(2'd0, 8'hA1); write(2'd1, 8'hB2);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL simul_pre level=%0d exp=2", level); end
    m_ready = 1'b1;
    write(2'd2, 8'hC3);
    checks++; if (level !== 3'd2 || chan_val !== 32'h4433_22A1) begin errors++; $display("FAIL simul_pushpop level=%0d chan_val=%h exp=2,443322A1", level, chan_val); end
    checks++; if (m_chan !== 2'd1 || m_data !== 8'hB2) begin errors++; $display("FAIL simul_order chan=%0d data=%h exp=1,B2", m_chan, m_data); end
    step(); step();
    m_ready = 1'b0;
    checks++; if (chan_val !== 32'h44C3_B2A1 || level !== 3'd0) begin errors++; $display("FAIL simul_drain chan_val=%h level=%0d exp=44C3B2A1,0", chan_val, level); end
  endtask

  task automatic test_back_to_back();
    m_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      write(2'd2, 8'(i));
      if (i == 1) begin
        checks++; if (level !== 3'd1 || chan_val[23:16] !== 8'hC3) begin errors++; $display("FAIL b2b_empty_pop level=%0d ch2=%h exp=1,C3", level, chan_val[23:16]); end
      end
    end
    checks++; if (level !== 3'd1 || chan_val[23:16] !== 8'h09) begin errors++; $display("FAIL b2b_steady level=%0d ch2=%h exp=1,09", level, chan_val[23:16]); end
    step();
    m_ready = 1'b0;
    checks++; if (chan_val !== 32'h440A_B2A1 || level !== 3'd0 || ovf !== 1'b0) begin errors++; $display("FAIL b2b_end chan_val=%h level=%0d ovf=%b exp=440AB2A1,0,0", chan_val, level, ovf); end
  endtask

  task automatic test_reset_mid();
    write(2'd0, 8'h01); write(2'd1, 8'h02); write(2'd2, 8'h03); write(2'd3, 8'h04);
    out_load = 1'b1; out_chan = 2'd0; bus_data = 8'h05; clr_ovf = 1'b1;
    step();
    out_load = 1'b0; clr_ovf = 1'b0;
    checks++; if (ovf !== 1'b1 || level !== 3'd4) begin errors++; $display("FAIL ovf_set_wins ovf=%b level=%0d exp=1,4", ovf, level); end
    m_ready = 1'b1; step(); step(); m_ready = 1'b0;
    checks++; if (level !== 3'd2 || chan_val !== 32'h440A_0201) begin errors++; $display("FAIL mid_pre level=%0d chan_val=%h exp=2,440A0201", level, chan_val); end
    reset = 1'b0;
    #1;
    checks++; if (level !== 3'd0 || chan_val !== 32'h0 || ovf !== 1'b0) begin errors++; $display("FAIL async_reset level=%0d chan_val=%h ovf=%b exp=0,0,0", level, chan_val, ovf); end
    m_ready = 1'b1;
    repeat (3) step();
    m_ready = 1'b0;
    reset = 1'b1;
    step();
    checks++; if (level !== 3'd0 || m_valid !== 1'b0 || chan_val !== 32'h0 || ovf !== 1'b0) begin errors++; $display("FAIL mid_reset level=%0d valid=%b chan_val=%h ovf=%b exp=0,0,0,0", level, m_valid, chan_val, ovf); end
  endtask

  task automatic test_invalid_chan();
    d3_load = 1'b1; d3_chan = 2'd2; d3_data = 8'h5A; d3_ready = 1'b1;
    step();
    d3_load = 1'b0;
    step();
    checks++; if (d3_chan_val !== 24'h5A_0000) begin errors++; $display("FAIL inv_pre got=%h exp=5A0000", d3_chan_val); end
    d3_ready = 1'b0; d3_load = 1'b1; d3_chan = 2'd3; d3_data = 8'hFF;
    step();
    d3_load = 1'b0;
    checks++; if (d3_level !== 3'd1 || d3_mchan !== 2'd3 || d3_mdata !== 8'hFF) begin errors++; $display("FAIL inv_accept level=%0d chan=%0d data=%h exp=1,3,FF", d3_level, d3_mchan, d3_mdata); end
    d3_ready = 1'b1;
    step();
    d3_ready = 1'b0;
    checks++; if (d3_chan_val !== 24'h5A_0000 || d3_level !== 3'd0) begin errors++; $display("FAIL inv_discard chan_val=%h level=%0d exp=5A0000,0", d3_chan_val, d3_level); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_overflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_invalid_chan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/out_port_bank.md
Name: out_port_bank

Overview:
- Parametrised successor to the single output register: buffers CPU OUT writes for NUM_CHANNELS output ports through a shared DEPTH-entry FIFO.
- Each FIFO entry is a tagged {channel, data} pair.
- Entries drain to an external consumer via valid/ready handshake.
- A per-channel display register latches each value as it is consumed.
- Sits between the control unit / data bus (driven by OUTA-style instructions) and board-level displays/peripherals.

Parameters:
- DATA_WIDTH, 8 (from arch_defs_pkg), width of data bus and channel registers
- NUM_CHANNELS, 4, number of output ports (>=1)
- DEPTH, 4, FIFO entries (power of two, >=2)
- CH_W, $clog2(NUM_CHANNELS) (min 1), channel index width (localparam)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- out_load  in  1  CPU write strobe (OUT instruction execute step)
- out_chan  in  CH_W  target channel of write
- bus_data  in  DATA_WIDTH  value to write (A register / data bus)
- out_full  out  1  FIFO full; control unit stalls OUT while high
- ovf  out  1  sticky overflow: write attempted while full
- clr_ovf  in  1  synchronous clear of ovf
- m_valid  out  1  head entry available
- m_ready  in  1  consumer accepts head
- m_chan  out  CH_W  channel of head entry
- m_data  out  DATA_WIDTH  data of head entry
- chan_val  out  NUM_CHANNELS*DATA_WIDTH  latched per-channel values, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset low, async):
  - FIFO pointers, count, ovf and all chan_val go to 0.
  - m_valid=0, out_full=0, level=0.
  - m_chan/m_data are don't-care but driven 0.
- Reset asserted mid-transfer discards all buffered entries. Nothing is flushed to chan_val.
- Push:
  - Occurs when out_load=1 and out_full=0 at a rising edge.
  - {out_chan, bus_data} is written to the tail and count increments.
- Push into a full FIFO:
  - Dropped, with no state change except ovf<=1.
  - out_full=1 rejects a push even if a pop occurs in the same cycle; no full-bypass.
- out_chan >= NUM_CHANNELS: the push is accepted. On pop the entry is discarded; no chan_val updates.
- Pop:
  - Occurs when m_valid=1 and m_ready=1 at a rising edge.
  - Head is removed and chan_val[m_chan] <= m_data in the same edge.
- m_valid:
  - m_valid = (count != 0).
  - Registered FIFO with no fall-through: a push into an empty FIFO gives m_valid=1 one cycle after the write edge.
  - Minimum write-to-chan_val latency is 2 edges (push edge, then pop edge with m_ready held high).
- m_chan/m_data are combinational reads of the head slot. They are stable while m_valid=1 and m_ready=0 (AXI-style hold rule).
- Simultaneous push and pop when 0 < count < DEPTH: both occur and count is unchanged.
- Simultaneous push and pop when count=0: only the push occurs; m_valid is 0, so no pop.
- Pointers are log2(DEPTH) bits and wrap naturally.
- out_full = (count == DEPTH); level = count.
- ovf and clr_ovf:
  - ovf is set by a dropped push and cleared by clr_ovf.
  - If both occur in one cycle, set wins.
- Multiple pops to the same channel: last popped value wins. chan_val holds until overwritten or reset.

Decomposition:
- arch_defs_pkg: DATA_WIDTH, plus new OUT_NUM_CHANNELS and OUT_FIFO_DEPTH constants used by the computer top level.
- Natural sub-module: sync_fifo, a generic parametrised WIDTH/DEPTH single-clock FIFO with push/pop, full, empty and count.
  - out_port_bank instantiates it with WIDTH = CH_W + DATA_WIDTH.
  - out_port_bank adds the overflow flag and channel demux/latch logic.

Test Plan:
- Reset: hold reset low 3 cycles mid-run with 2 entries queued -> level=0, m_valid=0, ovf=0, all chan_val=0x00 immediately after reset falls.
- Single write: out_load with chan=1, data=0x09, m_ready=0 -> next cycle m_valid=1, m_chan=1, m_data=0x09, level=1. Raise m_ready -> chan_val[1]=0x09 after the edge, level=0, m_valid=0.
- Fill/overflow (DEPTH=4, m_ready=0): write 0x11,0x22,0x33,0x44 to ch0..3 -> out_full=1, level=4. A 5th write of 0x55 -> ovf=1, level=4. Drain -> chan_val = {0x44,0x33,0x22,0x11}, 0x55 never appears. Pulse clr_ovf -> ovf=0.
- Simultaneous push/pop at level=2 -> level stays 2; FIFO order preserved (outputs 1st, 2nd, 3rd written in order).
- Wrap-around: 10 back-to-back writes to ch2 (0x01..0x0A) with m_ready=1 continuously -> no ovf, chan_val[2]=0x0A at end, pointers wrapped twice, level=0.
- Invalid channel (NUM_CHANNELS=3, CH_W=2): write chan=3, data=0xFF, then pop -> all chan_val unchanged, level returns to 0.
